imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time instruction-memory writer for the pipelined MIPS core.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Writes each word into instruction memory at consecutive word addresses, starting at a programmed base PC.
- Holds the core in reset until loading completes, then hands it the start PC and releases it.

Parameters:
- CNT_W, 9, width of the word-count field.
- MAX_WORDS, 256, largest legal load length in words; must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a load.
- base_addr  in  32  byte address of the first word; this is also the start PC.
- word_count  in  CNT_W  number of words to load.
- in_valid  in  1  in_data holds a word.
- in_data  in  32  instruction word.
- in_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte write address.
- mem_wdata  out  32  write data.
- core_rst  out  1  reset to the core, active-high.
- pc_load  out  1  one-cycle strobe; the core loads pc_init into its program counter.
- pc_init  out  32  start PC.
- busy  out  1  load in progress.
- done  out  1  load finished; the core is running.
- err  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, pc_load=0, pc_init=0, busy=0, done=0, err=0. State is IDLE.
- Reset mid-load aborts immediately; already-written memory words are not undone.
- States: IDLE, LOAD, FLUSH, RELEASE, RUN.
- IDLE, on start:
  - Rejected, with err pulsed for 1 cycle and state staying IDLE, if word_count==0, word_count>MAX_WORDS, or base_addr[1:0]!=0.
  - Otherwise base_addr and word_count are latched, the index is cleared, busy=1, and the next state is LOAD.
- LOAD:
  - in_ready=1, decoded combinationally from state.
  - A word is accepted on in_valid&&in_ready.
  - One cycle after acceptance (registered, latency 1): mem_we=1, mem_addr=base+4*index, mem_wdata=the word. The index then increments.
  - mem_we is 0 in every cycle that follows no acceptance.
  - Accepting the last word moves the state to FLUSH; in_ready is 0 from that next cycle on.
  - in_valid gaps of any length are legal; the loader waits with no timeout.
- FLUSH: 1 cycle. The final write is issued here. Next state is RELEASE.
- RELEASE: 1 cycle. pc_init=latched base, pc_load=1, core_rst still 1. Next state is RUN.
- RUN: core_rst=0, busy=0, done=1; pc_init holds its value.
  - A start in RUN re-arms the load: it applies the same validation as IDLE. If valid, core_rst=1 and done=0 in the next cycle and the state goes to LOAD. If invalid, err pulses and the state stays RUN.
- start in LOAD, FLUSH or RELEASE is ignored, with no err.
- Address arithmetic is modulo 2^32; base 0xFFFFFFFC followed by a second word wraps to address 0.
- Back-to-back acceptance, one word per cycle, is sustained at full throughput.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port load_sum (32 bits): the modulo-2^32 sum of all words accepted in the current load.
  - load_sum clears on an accepted start and is reset to 0.
  - load_sum is final and stable when done rises, and holds until the next accepted start.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with base_addr=100 and word_count=8. Stream 8 words with in_valid held high.
  - Required: writes to addresses 100,104,...,128 with matching data on 8 consecutive cycles.
  - Required: pc_load pulses once with pc_init=100; core_rst falls on the following cycle; done=1, busy=0.
- Same load with in_valid toggling 1/0 every cycle.
  - Required: 8 writes in order with no duplicates; mem_we is 0 in gap cycles.
- Rejected starts: word_count=0; word_count=257; base_addr=102.
  - Required for each: err pulses for exactly 1 cycle; busy stays 0; no mem_we; core_rst stays 1.
- Assert rst after 3 of 8 words are accepted.
  - Required: all outputs return to reset values immediately; a new start with base_addr=200 and 2 words writes to addresses 200 and 204.
- Base 0xFFFFFFFC, 2 words.
  - Required: writes to addresses 0xFFFFFFFC and 0x00000000.
- While in RUN, start with base_addr=400 and 1 word.
  - Required: core_rst=1 next cycle; write to address 400; pc_init=400.
  - With IMEM_LOADER_CHECKSUM_EN defined: load_sum equals that word.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams words into IMEM from a base PC,
// then releases the core. Optional running checksum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int CNT_W     = 9,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              pc_load,
    output logic [31:0]       pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       load_sum
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RELEASE, RUN} state_t;

    state_t             state;
    logic [31:0]        base_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   idx;
    logic               start_ok;
    logic               accept;
    logic               can_start;

    assign start_ok  = (word_count != '0) && (word_count <= CNT_W'(MAX_WORDS))
                       && (base_addr[1:0] == 2'b00);
    assign can_start = (state == IDLE) || (state == RUN);
    assign in_ready  = (state == LOAD);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            pc_load   <= 1'b0;
            pc_init   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            pc_load <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        if (start_ok) begin
                            base_q   <= base_addr;
                            cnt_q    <= word_count;
                            idx      <= '0;
                            busy     <= 1'b1;
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // byte address wraps modulo 2^32
                        mem_we    <= 1'b1;
                        mem_addr  <= base_q + 32'({idx, 2'b00});
                        mem_wdata <= in_data;
                        idx       <= idx + CNT_W'(1);
                        if (idx == cnt_q - CNT_W'(1))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    pc_load <= 1'b1;
                    pc_init <= base_q;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    core_rst <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_sum <= '0;
        else if (can_start && start && start_ok)
            load_sum <= '0;
        else if (accept)
            load_sum <= load_sum + in_data;
    end
`endif

endmodule
